// File: rtl/toggle_link_pkg.sv
// Shared definitions for the two-phase (toggle) event link: default
// synchroniser depth, default backlog counter width and the backlog limit.
package toggle_link_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 4;

  // Largest backlog a counter of width w can hold (2^w - 1).
  function automatic int unsigned max_backlog(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchroniser for a single asynchronous level. Used on the
// receive side for t_in and on the transmit side for ack_t.
module toggle_sync
  import toggle_link_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the asynchronous level through the flop chain; clr empties it.
  always_ff @(posedge clk) begin
    if (clr) begin
      chain_r <= {STAGES{1'b0}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/toggle_decoder.sv
// Receive end of a toggle event link: synchronises t_in, turns every level
// change into a buffered event, offers events on valid/ready and returns a
// toggle acknowledge for each consumed event.
module toggle_decoder
  import toggle_link_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int ARM_CYCLES  = SYNC_STAGES + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             t_in,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic             ack_t,
  output logic [CNT_W-1:0] pending,
  output logic             ovf,
  output logic             armed
);

  localparam int ARM_W = $clog2(ARM_CYCLES + 1);
  localparam logic [ARM_W-1:0] ARM_LAST  = ARM_W'(ARM_CYCLES);
  localparam logic [ARM_W-1:0] ARM_ONE   = ARM_W'(1);
  localparam logic [CNT_W-1:0] PEND_MAX  = CNT_W'(max_backlog(CNT_W));
  localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PEND_ZERO = {CNT_W{1'b0}};

  logic             t_s_s;
  logic             t_prev_r;
  logic [ARM_W-1:0] arm_cnt_r;
  logic             armed_r;
  logic [CNT_W-1:0] pending_r;
  logic             ev_valid_r;
  logic             ack_r;
  logic             ovf_r;

  logic             inc_s;
  logic             dec_s;
  logic [CNT_W-1:0] pend_nxt_s;
  logic             ovf_set_s;

  toggle_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .clr (clr),
    .d   (t_in),
    .q   (t_s_s)
  );

  // Next backlog value from this cycle's event and consume; a saturated
  // backlog drops a lone event and flags it, but event+consume is neutral.
  always_comb begin
    inc_s      = armed_r & (t_s_s != t_prev_r);
    dec_s      = ev_valid_r & ev_ready;
    pend_nxt_s = pending_r;
    ovf_set_s  = 1'b0;
    case ({inc_s, dec_s})
      2'b10: begin
        if (pending_r == PEND_MAX) begin
          ovf_set_s = 1'b1;
        end else begin
          pend_nxt_s = pending_r + PEND_ONE;
        end
      end
      2'b01: begin
        pend_nxt_s = pending_r - PEND_ONE;
      end
      default: begin
        pend_nxt_s = pending_r;
      end
    endcase
  end

  // Register edge history, arm window, backlog, acknowledge and overflow.
  always_ff @(posedge clk) begin
    if (clr) begin
      t_prev_r   <= 1'b0;
      arm_cnt_r  <= {ARM_W{1'b0}};
      armed_r    <= 1'b0;
      pending_r  <= PEND_ZERO;
      ev_valid_r <= 1'b0;
      ack_r      <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      // t_prev keeps tracking while disarmed so a line already high at
      // reset release does not look like an event once armed.
      t_prev_r   <= t_s_s;
      pending_r  <= pend_nxt_s;
      ev_valid_r <= (pend_nxt_s != PEND_ZERO);
      ack_r      <= ack_r ^ dec_s;
      ovf_r      <= ovf_r | ovf_set_s;
      if (!armed_r) begin
        arm_cnt_r <= arm_cnt_r + ARM_ONE;
        armed_r   <= ((arm_cnt_r + ARM_ONE) == ARM_LAST);
      end else begin
        arm_cnt_r <= arm_cnt_r;
        armed_r   <= armed_r;
      end
    end
  end

  assign ev_valid = ev_valid_r;
  assign ack_t    = ack_r;
  assign pending  = pending_r;
  assign ovf      = ovf_r;
  assign armed    = armed_r;

endmodule
